// File: rtl/branch_compare_pipe.sv
// rtl/branch_compare_pipe.sv - MIPS branch condition evaluator with registered valid/ready output stage
module branch_compare_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       mode,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_eq,
    output logic             out_lt,
    output logic [TAG_W-1:0] tag_out,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cmp_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] MODE_EQ  = 3'b000;
    localparam logic [2:0] MODE_NE  = 3'b001;
    localparam logic [2:0] MODE_LT  = 3'b010;
    localparam logic [2:0] MODE_GE  = 3'b011;
    localparam logic [2:0] MODE_LTU = 3'b100;
    localparam logic [2:0] MODE_GEU = 3'b101;
    localparam logic [2:0] MODE_GTZ = 3'b110;
    localparam logic [2:0] MODE_LEZ = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic eq;
    logic lt_s;
    logic lt_u;
    logic gtz;
    logic lt_sel;
    logic taken;
    logic accept;

    assign eq   = (a_in == b_in);
    assign lt_s = ($signed(a_in) < $signed(b_in));
    assign lt_u = (a_in < b_in);
    // Strictly positive: sign bit clear and at least one other bit set.
    assign gtz  = !a_in[WIDTH-1] && (|a_in);

    assign lt_sel = ((mode == MODE_LTU) || (mode == MODE_GEU)) ? lt_u : lt_s;

    always_comb begin
        taken = 1'b0;
        case (mode)
            MODE_EQ:  taken = eq;
            MODE_NE:  taken = !eq;
            MODE_LT:  taken = lt_s;
            MODE_GE:  taken = !lt_s;
            MODE_LTU: taken = lt_u;
            MODE_GEU: taken = !lt_u;
            MODE_GTZ: taken = gtz;
            MODE_LEZ: taken = !gtz;
            default:  taken = 1'b0;
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Flush wins over both a new accept and a consumer draining the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_taken <= 1'b0;
            out_eq    <= 1'b0;
            out_lt    <= 1'b0;
            tag_out   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_taken <= taken;
            out_eq    <= eq;
            out_lt    <= lt_sel;
            tag_out   <= tag_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_cnt   <= '0;
            taken_cnt <= '0;
        end else if (clr_cnt) begin
            cmp_cnt   <= '0;
            taken_cnt <= '0;
        end else if (accept) begin
            if (cmp_cnt != CNT_MAX) begin
                cmp_cnt <= cmp_cnt + 1'b1;
            end
            if (taken && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_compare_pipe.sv
// tb/tb_branch_compare_pipe.sv - randomized self-checking bench for branch_compare_pipe
module tb_branch_compare_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int CNT_W = 4;
    localparam longint CNT_MAX = (64'sd1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [2:0]       mode;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_eq;
    logic             out_lt;
    logic [TAG_W-1:0] tag_out;
    logic             clr_cnt;
    logic [CNT_W-1:0] cmp_cnt;
    logic [CNT_W-1:0] taken_cnt;

    branch_compare_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .mode(mode), .tag_in(tag_in),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_eq(out_eq), .out_lt(out_lt), .tag_out(tag_out),
        .clr_cnt(clr_cnt), .cmp_cnt(cmp_cnt), .taken_cnt(taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    bit     m_valid;
    bit     m_taken;
    bit     m_eq;
    bit     m_lt;
    longint m_tag;
    longint m_cmp;
    longint m_tk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sval(input logic [WIDTH-1:0] x);
        longint u;
        u = longint'(x);
        return x[WIDTH-1] ? u - (64'sd1 << WIDTH) : u;
    endfunction

    function automatic void ref_eval(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [2:0] md,
                                     output bit tk, output bit eq, output bit lt);
        longint sa, sb, ua, ub;
        sa = sval(a);
        sb = sval(b);
        ua = longint'(a);
        ub = longint'(b);
        eq = (ua == ub);
        lt = (md == 3'd4 || md == 3'd5) ? (ua < ub) : (sa < sb);
        case (md)
            3'd0: tk = (ua == ub);
            3'd1: tk = (ua != ub);
            3'd2: tk = (sa < sb);
            3'd3: tk = (sa >= sb);
            3'd4: tk = (ua < ub);
            3'd5: tk = (ua >= ub);
            3'd6: tk = (sa > 0);
            default: tk = (sa <= 0);
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_taken = 0; m_eq = 0; m_lt = 0; m_tag = 0; m_cmp = 0; m_tk = 0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] md, input logic [TAG_W-1:0] tg,
                         input bit vld, input bit ordy, input bit fl, input bit clr);
        bit ir, acc, tk, eq, lt;
        a_in = a; b_in = b; mode = md; tag_in = tg;
        in_valid = vld; out_ready = ordy; flush = fl; clr_cnt = clr;
        #1;
        ir  = !m_valid || ordy;
        acc = vld && ir && !fl;
        check("in_ready", in_ready, ir);
        ref_eval(a, b, md, tk, eq, lt);
        @(posedge clk);
        #1;
        if (fl) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_taken = tk; m_eq = eq; m_lt = lt; m_tag = tg;
        end else if (ordy) m_valid = 0;
        if (clr) begin
            m_cmp = 0; m_tk = 0;
        end else if (acc) begin
            if (m_cmp < CNT_MAX) m_cmp++;
            if (tk && m_tk < CNT_MAX) m_tk++;
        end
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_taken", out_taken, m_taken);
            check("out_eq", out_eq, m_eq);
            check("out_lt", out_lt, m_lt);
            check("tag_out", tag_out, m_tag);
        end
        check("cmp_cnt", cmp_cnt, m_cmp);
        check("taken_cnt", taken_cnt, m_tk);
    endtask

    initial begin
        longint saved;
        logic [WIDTH-1:0] ra, rb;
        checks = 0;
        failures = 0;
        model_reset();
        rst_n = 0; in_valid = 0; out_ready = 0; flush = 0; clr_cnt = 0;
        a_in = '0; b_in = '0; mode = '0; tag_in = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_cmp_cnt", cmp_cnt, 0);
        check("rst_taken_cnt", taken_cnt, 0);
        check("rst_tag_out", tag_out, 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Asynchronous reset between edges
        apply(5, 5, 3'd0, 5'd3, 1, 1, 0, 0);
        check("pre_rst_valid", out_valid, 1);
        rst_n = 0;
        #1;
        model_reset();
        check("async_rst_valid", out_valid, 0);
        check("async_rst_cmp", cmp_cnt, 0);
        check("async_rst_taken_cnt", taken_cnt, 0);
        check("async_rst_taken", out_taken, 0);
        #1;
        rst_n = 1;

        // Mode sweep
        apply(32'hFFFF_FFFF, 1, 3'd2, 0, 1, 1, 0, 0); check("sweep_lt", out_taken, 1);
        apply(32'hFFFF_FFFF, 1, 3'd4, 1, 1, 1, 0, 0); check("sweep_ltu", out_taken, 0);
        apply(32'hFFFF_FFFF, 1, 3'd5, 2, 1, 1, 0, 0); check("sweep_geu", out_taken, 1);
        apply(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd0, 3, 1, 1, 0, 0); check("sweep_eq", out_taken, 1);
        apply(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd1, 4, 1, 1, 0, 0); check("sweep_ne", out_taken, 0);
        apply(0, 32'h1234, 3'd6, 5, 1, 1, 0, 0); check("sweep_gtz", out_taken, 0);
        apply(0, 32'h1234, 3'd7, 6, 1, 1, 0, 0); check("sweep_lez", out_taken, 1);
        apply(32'h8000_0000, 32'h7FFF_FFFF, 3'd3, 7, 1, 1, 0, 0); check("sweep_ge_min", out_taken, 0);

        // Backpressure
        apply(0, 0, 3'd0, 0, 0, 1, 0, 1);
        apply(10, 15, 3'd1, 5'd7, 1, 0, 0, 0);
        check("bp_taken", out_taken, 1);
        check("bp_tag", tag_out, 7);
        for (int i = 0; i < 3; i++) apply(20, 20, 3'd0, 5'd9, 1, 0, 0, 0);
        check("bp_hold_cmp", cmp_cnt, 1);
        check("bp_hold_tag", tag_out, 7);
        apply(20, 20, 3'd0, 5'd9, 1, 1, 0, 0);
        check("bp_release_tag", tag_out, 9);

        // Flush priority with a pending result
        apply(1, 2, 3'd2, 5'd11, 1, 0, 0, 0);
        saved = longint'(cmp_cnt);
        apply(3, 3, 3'd0, 5'd12, 1, 1, 1, 0);
        check("flush_valid", out_valid, 0);
        check("flush_cmp", cmp_cnt, saved);

        // Counter saturation and clear-with-accept
        for (int i = 0; i < 20; i++) apply(i, i, 3'd0, i[TAG_W-1:0], 1, 1, 0, 0);
        check("sat_cmp", cmp_cnt, 15);
        check("sat_taken", taken_cnt, 15);
        apply(4, 4, 3'd0, 5'd1, 1, 1, 0, 1);
        check("clr_cmp", cmp_cnt, 0);
        check("clr_taken", taken_cnt, 0);

        // Throughput: tags 0..7 on consecutive cycles
        for (int i = 0; i < 8; i++) begin
            apply(i, 3, 3'd4, i[TAG_W-1:0], 1, 1, 0, 0);
            check("tput_tag", tag_out, i);
        end
        apply(0, 0, 3'd0, 0, 0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: rb = ~ra;
                2: begin ra = ra & 32'h8000_0001; rb = $urandom_range(0, 2); end
                default: rb = $urandom;
            endcase
            apply(ra, rb, 3'($urandom_range(0, 7)), TAG_W'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
